// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg -- shared definitions for the EX-stage multiply/divide unit.
//   op_e      : 3-bit mul/div-class opcode; bit 0 set means unsigned.
//   state_e   : FSM state encoding of ex_muldiv.
//   DIV_ITERS : number of radix-2 restoring iterations per divide.
//   `RegBus   : architectural register width (31:0).
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef DoubleRegBus
`define DoubleRegBus 63:0
`endif

package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5,
        OP_DIV   = 3'd6,
        OP_DIVU  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MACC    = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int unsigned DIV_ITERS = 32;
    localparam logic [5:0]  DIV_CNT_LAST = 6'(DIV_ITERS - 1);

endpackage

// File: rtl/ex_muldiv_div_core.sv
// div_core -- iterative 32-bit radix-2 restoring divider.
//   clk, rst          : clock, synchronous active-high reset
//   start             : load operands and begin (ignored when annul=1)
//   annul             : abort the running divide
//   sign_op           : treat dividend/divisor as two's complement
//   dividend, divisor : operands (divisor must be non-zero)
//   done              : high during the final iteration cycle
//   quotient, remainder : sign-corrected result, valid after done
`ifndef RegBus
`define RegBus 31:0
`endif

module div_core
    import ex_muldiv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           annul,
    input  logic           sign_op,
    input  logic [`RegBus] dividend,
    input  logic [`RegBus] divisor,
    output logic           done,
    output logic [`RegBus] quotient,
    output logic [`RegBus] remainder
);

    logic           run_q;
    logic [5:0]     cnt_q;
    logic [`RegBus] q_q;
    logic [`RegBus] r_q;
    logic [`RegBus] d_q;
    logic           neg_q_q;
    logic           neg_r_q;

    // Partial remainder shifted left with the next dividend bit; bit 32 of
    // the trial difference is the borrow that decides restore vs. keep.
    logic [32:0] partial;
    logic [32:0] diff;

    function automatic logic [`RegBus] mag(input logic [`RegBus] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

    assign partial = {r_q, q_q[31]};
    assign diff    = partial - {1'b0, d_q};
    assign done    = run_q && (cnt_q == DIV_CNT_LAST);

    // Quotient is negated when signs differ; remainder follows the dividend.
    assign quotient  = neg_q_q ? -q_q : q_q;
    assign remainder = neg_r_q ? -r_q : r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (annul) begin
            run_q <= 1'b0;
        end else if (start) begin
            run_q   <= 1'b1;
            cnt_q   <= '0;
            q_q     <= mag(dividend, sign_op);
            r_q     <= '0;
            d_q     <= mag(divisor, sign_op);
            neg_q_q <= sign_op && (dividend[31] ^ divisor[31]);
            neg_r_q <= sign_op && dividend[31];
        end else if (run_q) begin
            if (!diff[32]) begin
                r_q <= diff[31:0];
                q_q <= {q_q[30:0], 1'b1};
            end else begin
                r_q <= partial[31:0];
                q_q <= {q_q[30:0], 1'b0};
            end
            // Counter stops at the last count instead of wrapping.
            if (cnt_q == DIV_CNT_LAST) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv -- EX-stage HI/LO multiply, multiply-accumulate and divide unit.
//   clk, rst         : clock, synchronous active-high reset
//   op_valid, op     : mul/div-class instruction present in EX and its opcode
//   opnd_a, opnd_b   : forwarded rs/rt values
//   hi_in, lo_in     : forwarded current HI/LO
//   annul            : flush, abort anything in progress
//   hi_o, lo_o       : result toward EX/MEM HI/LO
//   hi_we, lo_we     : HI/LO write enables
//   stall_req        : freeze PC, IF/ID and ID/EX
//   busy             : FSM not idle
// Build option: define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU;
// otherwise those opcodes are silently dropped (no write, no stall).
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef DoubleRegBus
`define DoubleRegBus 63:0
`endif

module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    input  logic [2:0]     op,
    input  logic [`RegBus] opnd_a,
    input  logic [`RegBus] opnd_b,
    input  logic [`RegBus] hi_in,
    input  logic [`RegBus] lo_in,
    input  logic           annul,
    output logic [`RegBus] hi_o,
    output logic [`RegBus] lo_o,
    output logic           hi_we,
    output logic           lo_we,
    output logic           stall_req,
    output logic           busy
);

    op_e    op_k;
    state_e state_q, state_d;
    logic   dz_q, dz_d;
    logic   div_start, div_done;
    logic   [`RegBus] div_quot, div_rem;

    // Bit 0 of every opcode selects unsigned; sign-extend to 64 bits so a
    // single truncated multiply yields both signed and unsigned products.
    logic signed [32:0]          a_x, b_x;
    logic signed [`DoubleRegBus] a_w, b_w, prod;

    assign op_k = op_e'(op);
    assign a_x  = {~op[0] & opnd_a[31], opnd_a};
    assign b_x  = {~op[0] & opnd_b[31], opnd_b};
    assign a_w  = {{31{a_x[32]}}, a_x};
    assign b_w  = {{31{b_x[32]}}, b_x};
    assign prod = a_w * b_w;

    assign busy = (state_q != ST_IDLE);

`ifdef MULDIV_MADD_EN
    logic                  macc_load;
    logic                  sub_q;
    logic [`DoubleRegBus]  prod_q;
    logic [`DoubleRegBus]  acc;
    logic [`DoubleRegBus]  macc_res;

    assign acc      = {hi_in, lo_in};
    assign macc_res = sub_q ? (acc - prod_q) : (acc + prod_q);
`else
    logic unused_hilo;
    assign unused_hilo = ^{hi_in, lo_in};
`endif

    div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .annul     (annul),
        .sign_op   (~op[0]),
        .dividend  (opnd_a),
        .divisor   (opnd_b),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dz_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
            prod_q  <= '0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dz_q    <= dz_d;
`ifdef MULDIV_MADD_EN
            if (macc_load) begin
                prod_q <= prod;
                sub_q  <= (op_k == OP_MSUB) || (op_k == OP_MSUBU);
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        dz_d      = dz_q;
        div_start = 1'b0;
        hi_o      = '0;
        lo_o      = '0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        stall_req = 1'b0;
`ifdef MULDIV_MADD_EN
        macc_load = 1'b0;
`endif
        if (annul) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_k)
                            OP_MULT, OP_MULTU: begin
                                {hi_o, lo_o} = prod;
                                hi_we        = 1'b1;
                                lo_we        = 1'b1;
                            end
`ifdef MULDIV_MADD_EN
                            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                macc_load = 1'b1;
                                stall_req = 1'b1;
                                state_d   = ST_MACC;
                            end
`endif
                            OP_DIV, OP_DIVU: begin
                                stall_req = 1'b1;
                                if (opnd_b == '0) begin
                                    dz_d    = 1'b1;
                                    state_d = ST_DONE;
                                end else begin
                                    dz_d      = 1'b0;
                                    div_start = 1'b1;
                                    state_d   = ST_DIV_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
`ifdef MULDIV_MADD_EN
                ST_MACC: begin
                    {hi_o, lo_o} = macc_res;
                    hi_we        = 1'b1;
                    lo_we        = 1'b1;
                    state_d      = ST_IDLE;
                end
`endif
                ST_DIV_RUN: begin
                    stall_req = 1'b1;
                    if (div_done) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    state_d = ST_IDLE;
                    if (!dz_q) begin
                        hi_o = div_rem;
                        lo_o = div_quot;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_DIVU  = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] opnd_a, opnd_b, hi_in, lo_in;
    logic        annul;
    logic [31:0] hi_o, lo_o;
    logic        hi_we, lo_we, stall_req, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op        (op),
        .opnd_a    (opnd_a),
        .opnd_b    (opnd_b),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .annul     (annul),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .stall_req (stall_req),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_hi"},    64'(hi_o),      64'd0);
        check({tag, "_lo"},    64'(lo_o),      64'd0);
        check({tag, "_we"},    64'({hi_we, lo_we}), 64'd0);
        check({tag, "_stall"}, 64'(stall_req), 64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
    endtask

    // Issue a divide, scramble op/operands after the first edge, count the
    // stall cycles, then check the single DONE write and return to idle.
    task automatic do_div(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_stall);
        int n;
        n = 0;
        op_valid = 1'b1;
        op = o;
        opnd_a = a;
        opnd_b = b;
        #1;
        while (stall_req && n < 50) begin
            n++;
            tick();
            if (n == 1) begin
                op = OP_MULT;
                opnd_a = ~a;
                opnd_b = 32'd1;
                #1;
            end
        end
        check({tag, "_stalls"}, 64'(n), 64'(exp_stall));
        check({tag, "_hi"},     64'(hi_o), 64'(exp_hi));
        check({tag, "_lo"},     64'(lo_o), 64'(exp_lo));
        check({tag, "_we"},     64'({hi_we, lo_we}), 64'b11);
        check({tag, "_busy"},   64'(busy), 64'd1);
        op_valid = 1'b0;
        tick();
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_we"},   64'({hi_we, lo_we}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = OP_MULT; annul = 1'b0;
        opnd_a = '0; opnd_b = '0; hi_in = '0; lo_in = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_quiet("reset");

        // MULT -2 * 3
        op_valid = 1'b1; op = OP_MULT; opnd_a = 32'hFFFF_FFFE; opnd_b = 32'd3;
        #1;
        check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);
        check("mult_we", 64'({hi_we, lo_we}), 64'b11);
        check("mult_stall", 64'(stall_req), 64'd0);
        // MULTU on the same bits: 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
        op = OP_MULTU;
        #1;
        check("multu_hi", 64'(hi_o), 64'd2);
        check("multu_lo", 64'(lo_o), 64'hFFFF_FFFA);
        tick();
        check("mult_busy", 64'(busy), 64'd0);

        // annul has priority over op_valid
        annul = 1'b1; op = OP_MULT;
        #1;
        check("annul_idle_we", 64'({hi_we, lo_we}), 64'd0);
        annul = 1'b0; op_valid = 1'b0;
        tick();

`ifdef MULDIV_MADD_EN
        op_valid = 1'b1; op = OP_MADDU; hi_in = 32'd0; lo_in = 32'hFFFF_FFFF;
        opnd_a = 32'd1; opnd_b = 32'd1;
        #1;
        check("maddu_c0_stall", 64'(stall_req), 64'd1);
        check("maddu_c0_we", 64'({hi_we, lo_we}), 64'd0);
        tick();
        opnd_a = 32'd5;
        #1;
        check("maddu_hi", 64'(hi_o), 64'd1);
        check("maddu_lo", 64'(lo_o), 64'd0);
        check("maddu_we", 64'({hi_we, lo_we}), 64'b11);
        check("maddu_stall", 64'(stall_req), 64'd0);
        op_valid = 1'b0;
        tick();
        op_valid = 1'b1; op = OP_MSUB; hi_in = 32'd0; lo_in = 32'd0;
        opnd_a = 32'd2; opnd_b = 32'd3;
        #1;
        tick();
        op_valid = 1'b0;
        #1;
        check("msub_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("msub_lo", 64'(lo_o), 64'hFFFF_FFFA);
        tick();
        check("msub_busy", 64'(busy), 64'd0);
`else
        op_valid = 1'b1; op = OP_MADD; opnd_a = 32'd2; opnd_b = 32'd3;
        #1;
        check("madd_off_we", 64'({hi_we, lo_we}), 64'd0);
        check("madd_off_stall", 64'(stall_req), 64'd0);
        tick();
        check("madd_off_busy", 64'(busy), 64'd0);
        op_valid = 1'b0;
`endif

        do_div("div_m8_3",   OP_DIV,  32'hFFFF_FFF8, 32'd3,          32'hFFFF_FFFE, 32'hFFFF_FFFE, 33);
        do_div("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 33);
        do_div("div_m7_m2",  OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'd3,         33);
        do_div("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1,          32'd0,         32'hFFFF_FFFF, 33);
        do_div("divu_7_0",   OP_DIVU, 32'd7,         32'd0,          32'd0,         32'd0,         1);

        // annul during the divide
        op_valid = 1'b1; op = OP_DIVU; opnd_a = 32'd100; opnd_b = 32'd7;
        #1;
        repeat (11) tick();
        check("annul_run_stall", 64'(stall_req), 64'd1);
        annul = 1'b1; op_valid = 1'b0;
        #1;
        check("annul_cyc_stall", 64'(stall_req), 64'd0);
        check("annul_cyc_we", 64'({hi_we, lo_we}), 64'd0);
        tick();
        annul = 1'b0;
        #1;
        check_quiet("after_annul");
        do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        // reset in the middle of a divide
        op_valid = 1'b1; op = OP_DIV; opnd_a = 32'd1000; opnd_b = 32'd3;
        #1;
        repeat (5) tick();
        rst = 1'b1; op_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_quiet("rst_mid_div");
        repeat (35) begin
            tick();
            if (hi_we || lo_we || busy) break;
        end
        check("rst_no_late_write", 64'({hi_we, lo_we, busy}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
